// File: rtl/job_control_initiator.sv
// job_control_initiator: PSL-side sequencer for the CAPI job control interface.
// Issues registered one-cycle RESET/START commands with odd parity and tracks the
// AFU's done/running/error responses.
// Optional feature: define JOB_TIMEOUT_EN to bound the wait for ah_jdone after RESET
// to RESET_TIMEOUT cycles; otherwise the wait is unbounded and timeout stays 0.
module job_control_initiator #(
  parameter int unsigned RESET_TIMEOUT = 1024,
  parameter logic [7:0]  CMD_RESET     = 8'h80,
  parameter logic [7:0]  CMD_START     = 8'h90
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_reset,
  input  logic        req_start,
  input  logic [63:0] req_wed,
  output logic        ha_jval,
  output logic [7:0]  ha_jcom,
  output logic        ha_jcompar,
  output logic [63:0] ha_jea,
  output logic        ha_jeapar,
  input  logic        ah_jdone,
  input  logic        ah_jrunning,
  input  logic [63:0] ah_jerror,
  output logic        ready,
  output logic        busy,
  output logic        job_done,
  output logic [63:0] job_error,
  output logic        proto_error,
  output logic        timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StRstIssue,
    StRstWait,
    StReady,
    StStartIssue,
    StRunning
  } state_e;

  state_e      state_q, state_d;
  logic        jval_q, jval_d;
  logic [7:0]  jcom_q, jcom_d;
  logic [63:0] jea_q, jea_d;
  logic        job_done_q, job_done_d;
  logic [63:0] job_error_q, job_error_d;
  logic        proto_error_q, proto_error_d;
  logic        timeout_q, timeout_d;
  logic        wait_expired;

  // A zero timeout would make the terminal count unreachable.
  if (RESET_TIMEOUT == 0) begin : g_bad_timeout
    $error("RESET_TIMEOUT must be nonzero");
  end

`ifdef JOB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(RESET_TIMEOUT) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts cycles spent in RST_WAIT; held at zero elsewhere so it is clear on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == StRstWait) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Wait-counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wait_expired = (cnt_q == CntW'(RESET_TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  // Next-state, command generation and status flag updates.
  always_comb begin
    state_d       = state_q;
    jval_d        = 1'b0;
    jcom_d        = '0;
    jea_d         = '0;
    job_done_d    = 1'b0;
    job_error_d   = job_error_q;
    proto_error_d = proto_error_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (req_reset) state_d = StRstIssue;
      end
      StRstIssue: begin
        state_d = StRstWait;
      end
      StRstWait: begin
        // ah_jdone on the terminal-count cycle still completes the reset.
        if (ah_jdone) begin
          state_d = StReady;
        end else if (wait_expired) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      StReady: begin
        if (req_reset) begin
          state_d = StRstIssue;
        end else if (req_start) begin
          state_d = StStartIssue;
          jea_d   = req_wed;
        end
      end
      StStartIssue: begin
        state_d     = StRunning;
        job_error_d = '0;
      end
      StRunning: begin
        // An abort abandons the job, so a coincident ah_jdone is not reported.
        if (req_reset) begin
          state_d = StRstIssue;
        end else if (ah_jdone) begin
          state_d     = StIdle;
          job_done_d  = 1'b1;
          job_error_d = ah_jerror;
        end
      end
      default: state_d = StIdle;
    endcase

    // Commands are registered: ha_jval is high for the whole issue-state cycle.
    if (state_d == StRstIssue) begin
      jval_d = 1'b1;
      jcom_d = CMD_RESET;
    end else if (state_d == StStartIssue) begin
      jval_d = 1'b1;
      jcom_d = CMD_START;
    end

    if (ah_jdone && (state_q inside {StIdle, StReady, StRstIssue, StStartIssue})) begin
      proto_error_d = 1'b1;
    end
    // The cycle after START_ISSUE is always RUNNING, so it is already exempt here.
    if (ah_jrunning && (state_q != StRunning)) begin
      proto_error_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      jval_q        <= 1'b0;
      jcom_q        <= '0;
      jea_q         <= '0;
      job_done_q    <= 1'b0;
      job_error_q   <= '0;
      proto_error_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      jval_q        <= jval_d;
      jcom_q        <= jcom_d;
      jea_q         <= jea_d;
      job_done_q    <= job_done_d;
      job_error_q   <= job_error_d;
      proto_error_q <= proto_error_d;
      timeout_q     <= timeout_d;
    end
  end

  assign ha_jval     = jval_q;
  assign ha_jcom     = jcom_q;
  assign ha_jea      = jea_q;
  // Parity gated so the whole command bus is zero between commands.
  assign ha_jcompar  = jval_q & ~^jcom_q;
  assign ha_jeapar   = jval_q & ~^jea_q;
  assign ready       = (state_q == StReady);
  assign busy        = (state_q != StIdle) && (state_q != StReady);
  assign job_done    = job_done_q;
  assign job_error   = job_error_q;
  assign proto_error = proto_error_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_job_control_initiator.sv
// Self-checking bench for job_control_initiator: directed vector table, hand-written
// protocol/timeout sequences and randomized traffic against a behavioural model.
module tb_job_control_initiator;

  localparam int unsigned TO       = 16;
  localparam logic [7:0]  CmdReset = 8'h80;
  localparam logic [7:0]  CmdStart = 8'h90;
`ifdef JOB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, req_reset, req_start, ah_jdone, ah_jrunning;
  logic [63:0] req_wed, ah_jerror;
  logic        ha_jval, ha_jcompar, ha_jeapar, ready, busy, job_done, proto_error, timeout;
  logic [7:0]  ha_jcom;
  logic [63:0] ha_jea, job_error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  job_control_initiator #(
    .RESET_TIMEOUT(TO),
    .CMD_RESET    (CmdReset),
    .CMD_START    (CmdStart)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_reset  (req_reset),
    .req_start  (req_start),
    .req_wed    (req_wed),
    .ha_jval    (ha_jval),
    .ha_jcom    (ha_jcom),
    .ha_jcompar (ha_jcompar),
    .ha_jea     (ha_jea),
    .ha_jeapar  (ha_jeapar),
    .ah_jdone   (ah_jdone),
    .ah_jrunning(ah_jrunning),
    .ah_jerror  (ah_jerror),
    .ready      (ready),
    .busy       (busy),
    .job_done   (job_done),
    .job_error  (job_error),
    .proto_error(proto_error),
    .timeout    (timeout)
  );

  typedef struct {
    logic        rr, rs, jd, jr;
    logic [63:0] wed, jerr;
    logic        e_jval;
    logic [7:0]  e_com;
    logic [63:0] e_ea;
    logic        e_ready, e_busy, e_done;
    logic [63:0] e_jerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rr, logic rs, logic jd, logic jr, logic [63:0] wed,
                              logic [63:0] jerr, logic e_jval, logic [7:0] e_com,
                              logic [63:0] e_ea, logic e_ready, logic e_busy, logic e_done,
                              logic [63:0] e_jerr);
    vec_t v;
    v.rr = rr; v.rs = rs; v.jd = jd; v.jr = jr; v.wed = wed; v.jerr = jerr;
    v.e_jval = e_jval; v.e_com = e_com; v.e_ea = e_ea;
    v.e_ready = e_ready; v.e_busy = e_busy; v.e_done = e_done; v.e_jerr = e_jerr;
    return v;
  endfunction

  // Odd parity bit: set when the value holds an even number of ones.
  function automatic logic oddpar(logic [63:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_jval, input logic [7:0] e_com,
                           input logic [63:0] e_ea, input logic e_ready, input logic e_busy,
                           input logic e_done, input logic [63:0] e_jerr, input logic e_perr,
                           input logic e_tmo);
    chk({tag, ".jval"},    64'(ha_jval),     64'(e_jval));
    chk({tag, ".jcom"},    64'(ha_jcom),     64'(e_com));
    chk({tag, ".jcompar"}, 64'(ha_jcompar),  64'(e_jval && oddpar(64'(e_com))));
    chk({tag, ".jea"},     ha_jea,           e_ea);
    chk({tag, ".jeapar"},  64'(ha_jeapar),   64'(e_jval && oddpar(e_ea)));
    chk({tag, ".ready"},   64'(ready),       64'(e_ready));
    chk({tag, ".busy"},    64'(busy),        64'(e_busy));
    chk({tag, ".done"},    64'(job_done),    64'(e_done));
    chk({tag, ".jerr"},    job_error,        e_jerr);
    chk({tag, ".perr"},    64'(proto_error), 64'(e_perr));
    chk({tag, ".tmo"},     64'(timeout),     64'(e_tmo));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rr, input logic rs, input logic [63:0] wed, input logic jd,
                       input logic jr, input logic [63:0] jerr);
    req_reset = rr; req_start = rs; req_wed = wed;
    ah_jdone = jd; ah_jrunning = jr; ah_jerror = jerr;
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Behavioural model of the link, kept as "what has been issued / acknowledged".
  bit          m_valid, m_wait, m_ready, m_run, m_done, m_perr, m_tmo;
  logic [7:0]  m_cmd;
  logic [63:0] m_ea, m_jerr;
  int          m_wcnt;

  task automatic model_step(input logic rst, input logic rr, input logic rs, input logic [63:0] wed,
                            input logic jd, input logic jr, input logic [63:0] jerr);
    bit          n_valid;
    logic [7:0]  n_cmd;
    logic [63:0] n_ea;
    n_valid = 0; n_cmd = '0; n_ea = '0;
    if (rst) begin
      m_valid = 0; m_wait = 0; m_ready = 0; m_run = 0; m_done = 0;
      m_perr = 0; m_tmo = 0; m_cmd = '0; m_ea = '0; m_jerr = '0; m_wcnt = 0;
      return;
    end
    // Responses are only legal while a reset is awaited or a job is running.
    if (jd && !m_wait && !m_run) m_perr = 1;
    if (jr && !m_run) m_perr = 1;
    m_done = 0;
    if (m_valid) begin
      if (m_cmd == CmdReset) begin
        m_wait = 1; m_wcnt = 0;
      end else begin
        m_run = 1; m_jerr = '0;
      end
    end else if (m_wait) begin
      if (jd) begin
        m_wait = 0; m_ready = 1;
      end else if (TimeoutEn && m_wcnt == TO - 1) begin
        m_wait = 0; m_tmo = 1;
      end else begin
        m_wcnt++;
      end
    end else if (m_ready) begin
      if (rr) begin
        m_ready = 0; n_valid = 1; n_cmd = CmdReset;
      end else if (rs) begin
        m_ready = 0; n_valid = 1; n_cmd = CmdStart; n_ea = wed;
      end
    end else if (m_run) begin
      if (rr) begin
        m_run = 0; n_valid = 1; n_cmd = CmdReset;
      end else if (jd) begin
        m_run = 0; m_done = 1; m_jerr = jerr;
      end
    end else if (rr) begin
      n_valid = 1; n_cmd = CmdReset;
    end
    m_valid = n_valid; m_cmd = n_cmd; m_ea = n_ea;
  endtask

  localparam logic [63:0] Wed1 = 64'h0000_0001_0000_0000;
  localparam logic [63:0] Wed2 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] Wed3 = 64'h0000_0000_0000_1234;

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, 0, 0, '0);

    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    check_all("rst", 0, 8'h00, '0, 0, 0, 0, '0, 0, 0);

    // Directed table: reset handshake, job run, simultaneous requests, abort.
    //              rr rs jd jr wed   jerr  jval com    ea    rdy bsy dn jerr
    tbl.push_back(mk(1, 0, 0, 0, '0,   '0,   1, CmdReset, '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 1, 0, '0,   '0,   0, 8'h00,    '0,   1, 0, 0, 64'd0));
    tbl.push_back(mk(0, 1, 0, 0, Wed1, '0,   1, CmdStart, Wed1, 0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 1, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 1, 1, '0,   64'd5, 0, 8'h00,   '0,   0, 0, 1, 64'd5));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 0, 0, 64'd5));
    tbl.push_back(mk(1, 0, 0, 0, '0,   '0,   1, CmdReset, '0,   0, 1, 0, 64'd5));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd5));
    tbl.push_back(mk(0, 0, 1, 0, '0,   '0,   0, 8'h00,    '0,   1, 0, 0, 64'd5));
    tbl.push_back(mk(1, 1, 0, 0, Wed2, '0,   1, CmdReset, '0,   0, 1, 0, 64'd5));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd5));
    tbl.push_back(mk(0, 0, 1, 0, '0,   '0,   0, 8'h00,    '0,   1, 0, 0, 64'd5));
    tbl.push_back(mk(0, 1, 0, 0, Wed3, '0,   1, CmdStart, Wed3, 0, 1, 0, 64'd5));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 1, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(1, 0, 0, 1, '0,   '0,   1, CmdReset, '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 0, 0, '0,   '0,   0, 8'h00,    '0,   0, 1, 0, 64'd0));
    tbl.push_back(mk(0, 0, 1, 0, '0,   64'd7, 0, 8'h00,   '0,   1, 0, 0, 64'd0));
    foreach (tbl[i]) begin
      drive(tbl[i].rr, tbl[i].rs, tbl[i].wed, tbl[i].jd, tbl[i].jr, tbl[i].jerr);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].e_jval, tbl[i].e_com, tbl[i].e_ea,
                tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_jerr, 0, 0);
    end

    // Protocol error: ah_jdone in IDLE is sticky across traffic until reset.
    do_reset();
    drive(0, 0, '0, 1, 0, '0);
    tick();
    check_all("perr_set", 0, 8'h00, '0, 0, 0, 0, '0, 1, 0);
    drive(0, 0, '0, 0, 0, '0);
    tick();
    tick();
    check_all("perr_hold", 0, 8'h00, '0, 0, 0, 0, '0, 1, 0);
    drive(1, 0, '0, 0, 0, '0);
    tick();
    check_all("perr_cmd", 1, CmdReset, '0, 0, 1, 0, '0, 1, 0);
    drive(0, 0, '0, 0, 0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("perr_clr", 0, 8'h00, '0, 0, 0, 0, '0, 0, 0);

`ifdef JOB_TIMEOUT_EN
    // Timeout after TO cycles in RST_WAIT; then ah_jdone on the terminal cycle wins.
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      drive(1, 0, '0, 0, 0, '0);
      tick();
      drive(0, 0, '0, 0, 0, '0);
      tick();
      check_all($sformatf("tmo%0d_enter", rep), 0, 8'h00, '0, 0, 1, 0, '0, 0, 0);
      for (int w = 0; w < TO; w++) begin
        ah_jdone = (rep == 1) && (w == TO - 1);
        tick();
        if (w < TO - 1) begin
          chk($sformatf("tmo%0d_wait%0d.busy", rep, w), 64'(busy), 64'd1);
          chk($sformatf("tmo%0d_wait%0d.tmo", rep, w), 64'(timeout), 64'd0);
        end
      end
      ah_jdone = 1'b0;
      if (rep == 0) check_all("tmo0_fire", 0, 8'h00, '0, 0, 0, 0, '0, 0, 1);
      else          check_all("tmo1_done", 0, 8'h00, '0, 1, 0, 0, '0, 0, 0);
      tick();
      if (rep == 0) check_all("tmo0_sticky", 0, 8'h00, '0, 0, 0, 0, '0, 0, 1);
      else          check_all("tmo1_ready", 0, 8'h00, '0, 1, 0, 0, '0, 0, 0);
    end
`else
    // Without the timeout feature RST_WAIT waits indefinitely.
    do_reset();
    drive(1, 0, '0, 0, 0, '0);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    for (int w = 0; w < 3 * TO; w++) tick();
    check_all("notmo_wait", 0, 8'h00, '0, 0, 1, 0, '0, 0, 0);
    drive(0, 0, '0, 1, 0, '0);
    tick();
    check_all("notmo_done", 0, 8'h00, '0, 1, 0, 0, '0, 0, 0);
`endif

    // Randomized traffic against the behavioural model.
    do_reset();
    model_step(1, 0, 0, '0, 0, 0, '0);
    for (int c = 0; c < 3000; c++) begin
      logic        rst, rr, rs, jd, jr;
      logic [63:0] wed, jerr;
      rst  = ($urandom_range(0, 199) == 0);
      rr   = ($urandom_range(0, 9) == 0);
      rs   = ($urandom_range(0, 2) == 0);
      jd   = (m_wait || m_run) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      jr   = m_run ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 59) == 0);
      wed  = {$urandom(), $urandom()};
      jerr = {$urandom(), $urandom()};
      reset = rst;
      drive(rr, rs, wed, jd, jr, jerr);
      tick();
      model_step(rst, rr, rs, wed, jd, jr, jerr);
      check_all($sformatf("rnd%0d", c), m_valid, m_cmd, m_ea, m_ready,
                m_valid || m_wait || m_run, m_done, m_jerr, m_perr, m_tmo);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/job_control_initiator.md
Name: job_control_initiator

Overview:
- PSL-side driver for the CAPI job control interface; it sits at the opposite end of the link from an AFU's job handler.
- Takes software-level reset/start requests and issues single-cycle ha_jval/ha_jcom/ha_jea commands with odd parity.
- Tracks the AFU's ah_jdone/ah_jerror/ah_jrunning responses and reports job status upward.
- Used as the host-side model in AFU simulation benches and as the job sequencer in the PSL emulation top.

Parameters:
- RESET_TIMEOUT, 1024, cycles to wait for ah_jdone after RESET before flagging timeout (only with JOB_TIMEOUT_EN)
- CMD_RESET, 8'h80, ha_jcom encoding for RESET
- CMD_START, 8'h90, ha_jcom encoding for START

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_reset  in  1  pulse: request an AFU reset
- req_start  in  1  pulse: request job start
- req_wed  in  64  work element descriptor sampled with req_start
- ha_jval  out  1  job command valid, one-cycle pulse
- ha_jcom  out  8  job command code
- ha_jcompar  out  1  odd parity over ha_jcom
- ha_jea  out  64  effective address (WED for START, 0 for RESET)
- ha_jeapar  out  1  odd parity over ha_jea
- ah_jdone  in  1  AFU done pulse
- ah_jrunning  in  1  AFU running level
- ah_jerror  in  64  error code, valid with ah_jdone
- ready  out  1  high in READY state (reset complete, start accepted)
- busy  out  1  high in any state other than IDLE and READY
- job_done  out  1  one-cycle pulse when a started job completes
- job_error  out  64  ah_jerror captured at job completion; holds until next START
- proto_error  out  1  sticky: unexpected ah_jdone, or ah_jrunning outside RUNNING; cleared only by reset
- timeout  out  1  sticky RESET timeout flag (0 when feature absent)

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - job_error = 0.
- States: IDLE, RST_ISSUE, RST_WAIT, READY, START_ISSUE, RUNNING.
- IDLE:
  - req_reset -> RST_ISSUE.
  - req_start ignored.
- RST_ISSUE (1 cycle):
  - Drive ha_jval=1, ha_jcom=CMD_RESET, ha_jea=0.
  - Next state RST_WAIT.
- RST_WAIT:
  - ah_jdone -> READY.
  - ah_jerror ignored on RESET completion.
  - ah_jdone may arrive any cycle >=1 after the ha_jval cycle; there is no upper bound without the timeout feature.
- READY:
  - req_start -> START_ISSUE; req_wed latched the same cycle.
  - req_reset -> RST_ISSUE.
  - If both are asserted in the same cycle, req_reset wins.
- START_ISSUE (1 cycle):
  - Drive ha_jval=1, ha_jcom=CMD_START, ha_jea=latched WED.
  - Clear job_error.
  - Next state RUNNING.
- RUNNING:
  - ah_jdone -> capture ah_jerror into job_error, pulse job_done the next cycle, go to IDLE.
  - An AFU requires a new RESET before each job.
  - req_reset in RUNNING -> RST_ISSUE; the in-flight job is abandoned and no job_done is pulsed.
- ha_jval outputs:
  - Registered; high for exactly one cycle per command; never on consecutive cycles.
  - ha_jcom, ha_jea and parities are 0 whenever ha_jval=0.
- Parity: odd; ha_jcompar = ~^ha_jcom, ha_jeapar = ~^ha_jea, computed on the registered values.
- proto_error is set by:
  - ah_jdone in IDLE, READY, RST_ISSUE or START_ISSUE;
  - ah_jrunning=1 in any state other than RUNNING, ignoring the first cycle after START_ISSUE.
- Request handling:
  - req_start outside READY and req_reset during RST_ISSUE/RST_WAIT are dropped; no queueing.
- reset mid-operation: FSM returns to IDLE next cycle, ha_jval deasserted, all sticky flags cleared.

Optional Feature:
- Macro JOB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RST_WAIT and increments each cycle in RST_WAIT.
  - On reaching RESET_TIMEOUT with no ah_jdone: set timeout, go to IDLE.
  - If ah_jdone arrives on the terminal-count cycle, ah_jdone wins (READY, no timeout).
- When undefined: no counter; timeout tied to 0; RST_WAIT waits indefinitely.

Test Plan:
- Reset handshake: reset deasserted; req_reset pulse; AFU ah_jdone 3 cycles after ha_jval.
  - Expect exactly one ha_jval cycle with ha_jcom=8'h80, ha_jcompar=0, ha_jea=0, ha_jeapar=1.
  - Expect ready=1 the cycle after ah_jdone.
- Job run: from READY, req_start with req_wed=64'h0000_0001_0000_0000; AFU raises ah_jrunning, then ah_jdone with ah_jerror=64'h5.
  - Expect ha_jcom=8'h90, ha_jea=WED, ha_jeapar=0.
  - Expect job_done pulse, job_error=5, state IDLE.
- Simultaneous req_reset and req_start in READY -> RESET command issued, no START, WED not latched.
- Abort: req_reset while RUNNING -> RESET issued next cycle; no job_done; after ah_jdone, ready=1.
- Protocol error: ah_jdone pulse in IDLE -> proto_error=1 and sticky until reset; FSM unchanged.
- With JOB_TIMEOUT_EN, RESET_TIMEOUT=16, AFU never responds -> timeout=1 exactly 16 cycles after entering RST_WAIT, FSM in IDLE.
  - Repeat with ah_jdone on cycle 16 -> ready=1, timeout=0.
